// File: rtl/count_window_gen_if.sv
// Configuration offer channel for count_window_gen: start/stop pair
// with a valid/ready handshake.
interface count_window_gen_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] cfg_start;
   logic [WIDTH-1:0] cfg_stop;
   logic             cfg_valid;
   logic             cfg_ready;

   modport master (
      output cfg_start,
      output cfg_stop,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_start,
      input  cfg_stop,
      input  cfg_valid,
      output cfg_ready
   );
endinterface

// File: rtl/count_window_gen.sv
// Period-aligned gating pulse from a free-running count and a start/stop pair.
// Optional watchdog on over-long windows: define WINDOW_WDOG_EN.
module count_window_gen #(
   parameter int WIDTH      = 16,
   parameter int CNT_W      = 8,
   parameter int MAX_ACTIVE = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   count_window_gen_if.slave cfg,
   output logic             pulse_out,
   output logic [CNT_W-1:0] pulse_count,
   output logic             cfg_err,
   output logic             wdog_err
);
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WAIT_START = 2'd1;
   localparam logic [1:0] ACTIVE     = 2'd2;
   localparam logic [1:0] DONE       = 2'd3;

   if (MAX_ACTIVE < 1) begin : g_chk
      $error("MAX_ACTIVE must be at least 1");
   end

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] pend_start;
   logic [WIDTH-1:0] pend_stop;
   logic [WIDTH-1:0] act_start;
   logic [WIDTH-1:0] act_stop;
   logic [WIDTH-1:0] eff_start;
   logic [WIDTH-1:0] eff_stop;
   logic             pend_full;
   logic             boundary;
   logic             apply;
   logic             xfer;
   logic             wdog_hit;

   assign boundary      = (count == '0);
   assign apply         = boundary & pend_full;
   assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
   assign cfg.cfg_ready = ~pend_full;

   // A boundary-cycle start match must see the value being applied now.
   assign eff_start = apply ? pend_start : act_start;
   assign eff_stop  = apply ? pend_stop  : act_stop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_full  <= 1'b0;
         pend_start <= '0;
         pend_stop  <= '0;
         act_start  <= '0;
         act_stop   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         if (apply) begin
            act_start <= pend_start;
            act_stop  <= pend_stop;
            pend_full <= 1'b0;
            if (pend_start == pend_stop)
               cfg_err <= 1'b1;
         end
         if (xfer) begin
            pend_start <= cfg.cfg_start;
            pend_stop  <= cfg.cfg_stop;
            pend_full  <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:
               state_nxt = WAIT_START;
            WAIT_START:
               if (count == eff_start && eff_start != eff_stop)
                  state_nxt = ACTIVE;
            ACTIVE:
               if (count == act_stop || wdog_hit)
                  state_nxt = DONE;
            DONE:
               if (boundary)
                  state_nxt = WAIT_START;
            default:
               state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pulse_out   <= 1'b0;
         pulse_count <= '0;
      end else begin
         state     <= state_nxt;
         pulse_out <= (state_nxt == ACTIVE);
         if (state_nxt == ACTIVE && !pulse_out && pulse_count != '1)
            pulse_count <= pulse_count + 1'b1;
      end
   end

`ifdef WINDOW_WDOG_EN
   localparam int WD_W = $clog2(MAX_ACTIVE + 1);

   logic [WD_W-1:0] wd_cnt;

   // wd_cnt holds cycles already spent in ACTIVE before this edge.
   assign wdog_hit = (state == ACTIVE) &&
                     (wd_cnt == WD_W'(MAX_ACTIVE - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt   <= '0;
         wdog_err <= 1'b0;
      end else begin
         if (state == ACTIVE && state_nxt == ACTIVE)
            wd_cnt <= wd_cnt + 1'b1;
         else
            wd_cnt <= '0;
         if (wdog_hit && enable)
            wdog_err <= 1'b1;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign wdog_err = 1'b0;
`endif

endmodule
